fmas_nrm_rnd: RTL and testbench

//  Final stage of the single-precision FMA pipeline. Consumes the unrounded magnitude and exponent from the add stage.

---
 rtl/fmas_pkg.sv | 46 ++++
 rtl/fmas_nrm_rnd_if.sv | 37 +++
 rtl/fmas_lzc.sv | 24 ++
 rtl/fmas_nrm_rnd.sv | 221 ++++++++++++++++++++++
 tb/tb_fmas_nrm_rnd.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/fmas_pkg.sv
// Shared types and constants for the FMA normalize/round stage.
// Holds the rounding-mode enum, flag bit positions, binary32 constants
// and the per-mode round-increment decision.
package fmas_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rm_e;

  // Bit positions inside the 5-bit flag vector {NV,DZ,OF,UF,NX}.
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam int          BIAS = 127;
  localparam int          EMAX = 2 * BIAS + 1;  // all-ones exponent field
  localparam logic [31:0] QNAN = 32'h7fc00000;
  localparam logic [30:0] MAXF = 31'h7f7fffff;

  // Significand bits kept in the result (hidden bit included).
  localparam int SIG_W   = 24;
  // Right-shift cap for denormalization: beyond this every bit already
  // lands below the guard position, so a larger shift changes nothing.
  localparam int DEN_CAP = 26;

  // Whether the kept significand is bumped by one ulp.
  function automatic logic round_inc(input rm_e rm, input logic sign,
                                     input logic guard, input logic st,
                                     input logic lsb);
    case (rm)
      RNE:     return guard && (st || lsb);
      RTZ:     return 1'b0;
      RDN:     return sign && (guard || st);
      RUP:     return !sign && (guard || st);
      RMM:     return guard;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fmas_nrm_rnd_if.sv
// Upstream/downstream bundle of the normalize/round stage.
// Valid/ready: a beat moves on a rising clock edge where valid && ready;
// the sender holds valid and payload stable until that edge, and ready may
// depend combinationally on the receiver's own downstream ready.
interface fmas_nrm_rnd_if #(
  parameter int MANT_W = 82,
  parameter int EXP_W  = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [MANT_W-1:0]       in_mant;
  logic                    in_sticky;
  logic [2:0]              in_rm;
  logic                    in_nan;
  logic                    in_invalid;
  logic                    in_inf;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             rslt;
  logic [4:0]              flag;

  // Producer of beats and consumer of results.
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, in_rm,
           in_nan, in_invalid, in_inf, out_ready,
    input  in_ready, out_valid, rslt, flag
  );

  // The normalize/round stage itself.
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_rm,
           in_nan, in_invalid, in_inf, out_ready,
    output in_ready, out_valid, rslt, flag
  );
endinterface

// File: rtl/fmas_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fmas_lzc #(
  parameter int W  = 82,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  logic found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    cnt   = CW'(W);
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && din[i]) begin
        cnt   = CW'(W - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmas_nrm_rnd.sv
// Final FMA stage: normalize (S1) then round/pack (S2), valid/ready both
// sides, one beat per cycle. Build option FMAS_NRM_FTZ_EN flushes tiny
// non-zero results to signed zero and skips the denormalize shift.
module fmas_nrm_rnd
  import fmas_pkg::*;
#(
  parameter int MANT_W = 82,
  parameter int EXP_W  = 10
) (
  input  logic            clk,
  input  logic            reset,
  fmas_nrm_rnd_if.slave   io
);

  localparam int LZ_W  = $clog2(MANT_W + 1);
  localparam int E_W   = EXP_W + 2;
  localparam int G_BIT = MANT_W - SIG_W - 1;

  localparam logic signed [E_W-1:0] E_ZERO = '0;
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'(EMAX);

  // Pipeline control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_en, s1_move, in_fire;

  // S1 register contents
  logic                  s1_sign_q,    s1_sign_d;
  logic signed [E_W-1:0] s1_e_q,       s1_e_d;
  logic [MANT_W-1:0]     s1_m_q,       s1_m_d;
  logic                  s1_sticky_q,  s1_sticky_d;
  rm_e                   s1_rm_q,      s1_rm_d;
  logic                  s1_nan_q,     s1_nan_d;
  logic                  s1_invalid_q, s1_invalid_d;
  logic                  s1_inf_q,     s1_inf_d;

  // S2 register contents (the visible outputs)
  logic [31:0] rslt_q, rslt_d;
  logic [4:0]  flag_q, flag_d;

  // S1 datapath
  logic [LZ_W-1:0]       lz;
  logic [MANT_W-1:0]     m_norm, m_s1;
  logic signed [E_W-1:0] e_norm, e_s1;
  logic                  st_s1;

  // S2 datapath
  logic [SIG_W-1:0]      kept, mant_r;
  logic                  guard, st, inc, nx, tiny, is_zero, of, ovf_inf;
  logic [SIG_W:0]        sum;
  logic signed [E_W-1:0] e_post;
  logic [31:0]           res_num;
  logic [4:0]            flg_num;
  logic                  lint_unused;

  fmas_lzc #(.W(MANT_W)) u_lzc (
    .din (io.in_mant),
    .cnt (lz)
  );

  assign io.in_ready  = !s1_valid_q || s1_move;
  assign io.out_valid = s2_valid_q;
  assign io.rslt      = rslt_q;
  assign io.flag      = flag_q;

  // Handshake: S2 refills when empty or drained; S1 refills when it empties into S2.
  always_comb begin
    s2_en      = !s2_valid_q || io.out_ready;
    s1_move    = s1_valid_q && s2_en;
    in_fire    = io.in_valid && io.in_ready;
    s1_valid_d = in_fire || (s1_valid_q && !s1_move);
    s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
  end

  // S1: left-normalize, then (gradual underflow) shift right into the subnormal range.
`ifdef FMAS_NRM_FTZ_EN
  always_comb begin
    m_norm = io.in_mant << lz;
    e_norm = E_W'(io.in_exp) - E_W'(lz);
    m_s1   = m_norm;
    st_s1  = io.in_sticky;
    e_s1   = (io.in_mant == '0) ? E_ZERO : e_norm;
  end
`else
  logic signed [E_W-1:0] sh_full;
  logic [4:0]            sh;
  logic [MANT_W-1:0]     den_mask;

  always_comb begin
    m_norm   = io.in_mant << lz;
    e_norm   = E_W'(io.in_exp) - E_W'(lz);
    sh_full  = E_ONE - e_norm;
    sh       = (sh_full > E_W'(DEN_CAP)) ? 5'(DEN_CAP) : sh_full[4:0];
    den_mask = ~({MANT_W{1'b1}} << sh);
    m_s1     = m_norm;
    st_s1    = io.in_sticky;
    e_s1     = e_norm;
    if (io.in_mant == '0) begin
      e_s1 = E_ZERO;
    end else if (e_norm <= E_ZERO) begin
      m_s1  = m_norm >> sh;
      st_s1 = io.in_sticky || (|(m_norm & den_mask));
      e_s1  = E_ZERO;
    end
  end
`endif

  // S1 load: capture the normalized beat when it is accepted.
  always_comb begin
    s1_sign_d    = s1_sign_q;
    s1_e_d       = s1_e_q;
    s1_m_d       = s1_m_q;
    s1_sticky_d  = s1_sticky_q;
    s1_rm_d      = s1_rm_q;
    s1_nan_d     = s1_nan_q;
    s1_invalid_d = s1_invalid_q;
    s1_inf_d     = s1_inf_q;
    if (in_fire) begin
      s1_sign_d    = io.in_sign;
      s1_e_d       = e_s1;
      s1_m_d       = m_s1;
      s1_sticky_d  = st_s1;
      s1_rm_d      = rm_e'(io.in_rm);
      s1_nan_d     = io.in_nan;
      s1_invalid_d = io.in_invalid;
      s1_inf_d     = io.in_inf;
    end
  end

  // S2: round, detect overflow/underflow, apply specials, pack.
  always_comb begin
    kept    = s1_m_q[MANT_W-1 -: SIG_W];
    guard   = s1_m_q[G_BIT];
    st      = (|s1_m_q[G_BIT-1:0]) || s1_sticky_q;
    inc     = round_inc(s1_rm_q, s1_sign_q, guard, st, kept[0]);
    sum     = {1'b0, kept} + {{SIG_W{1'b0}}, inc};
    mant_r  = sum[SIG_W-1:0];
    e_post  = s1_e_q;
    if (sum[SIG_W]) begin
      mant_r = sum[SIG_W:1];
      e_post = s1_e_q + E_ONE;
    end else if (s1_e_q == E_ZERO && sum[SIG_W-1]) begin
      // Subnormal rounded up into the hidden bit: smallest normal.
      e_post = E_ONE;
    end
    nx      = guard || st;
    tiny    = (s1_e_q <= E_ZERO);
    is_zero = (s1_m_q == '0) && !s1_sticky_q;
    of      = (e_post >= E_MAX);
    ovf_inf = (s1_rm_q == RNE) || (s1_rm_q == RMM) ||
              (s1_rm_q == RDN && s1_sign_q) || (s1_rm_q == RUP && !s1_sign_q);

    res_num = {s1_sign_q, e_post[7:0], mant_r[SIG_W-2:0]};
    flg_num = '0;
    flg_num[FLG_NX] = nx;
    flg_num[FLG_UF] = tiny && nx;
    if (is_zero) begin
      res_num = {s1_sign_q, 31'b0};
      flg_num = '0;
`ifdef FMAS_NRM_FTZ_EN
    end else if (tiny) begin
      res_num = {s1_sign_q, 31'b0};
      flg_num = '0;
      flg_num[FLG_UF] = 1'b1;
      flg_num[FLG_NX] = 1'b1;
`endif
    end else if (of) begin
      res_num = ovf_inf ? {s1_sign_q, 8'hff, 23'b0} : {s1_sign_q, MAXF};
      flg_num = '0;
      flg_num[FLG_OF] = 1'b1;
      flg_num[FLG_NX] = 1'b1;
    end

    rslt_d = rslt_q;
    flag_d = flag_q;
    if (s1_move) begin
      if (s1_nan_q) begin
        rslt_d = QNAN;
        flag_d = '0;
        flag_d[FLG_NV] = s1_invalid_q;
      end else if (s1_inf_q) begin
        rslt_d = {s1_sign_q, 8'hff, 23'b0};
        flag_d = '0;
      end else begin
        rslt_d = res_num;
        flag_d = flg_num;
      end
    end
  end

  assign lint_unused = ^{mant_r[SIG_W-1], e_post[E_W-1:8]};

  // Control and output registers; reset drops any in-flight beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      rslt_q     <= '0;
      flag_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      rslt_q     <= rslt_d;
      flag_q     <= flag_d;
    end
  end

  // S1 payload registers; meaningful only while s1_valid_q is set.
  always_ff @(posedge clk) begin
    s1_sign_q    <= s1_sign_d;
    s1_e_q       <= s1_e_d;
    s1_m_q       <= s1_m_d;
    s1_sticky_q  <= s1_sticky_d;
    s1_rm_q      <= s1_rm_d;
    s1_nan_q     <= s1_nan_d;
    s1_invalid_q <= s1_invalid_d;
    s1_inf_q     <= s1_inf_d;
  end

endmodule

// File: tb/tb_fmas_nrm_rnd.sv
// Bench for fmas_nrm_rnd: directed vectors with hand-derived results,
// expected queue filled by the driver, popped by an output monitor.
// Expected values follow the FMAS_NRM_FTZ_EN build setting.
module tb_fmas_nrm_rnd;
  import fmas_pkg::*;

  localparam int MANT_W = 82;
  localparam int EXP_W  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [36:0] exp_q[$];
  string       name_q[$];
  logic [36:0] mon_exp;
  string       mon_name;

  fmas_nrm_rnd_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) io ();

  fmas_nrm_rnd #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every accepted output beat is compared against the queue head.
  always @(negedge clk) begin
    if (!reset && io.out_valid && io.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h_%h, expected no beat", io.rslt, io.flag);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, {io.rslt, io.flag}, mon_exp);
      end
    end
  end

  // Driver: present one beat, wait (bounded) for in_ready, queue its expected result.
  task automatic send(input string name, input logic sign, input logic signed [EXP_W-1:0] e,
                      input logic [MANT_W-1:0] m, input logic sticky, input logic [2:0] rm,
                      input logic nan, input logic inv, input logic inf,
                      input logic [31:0] r, input logic [4:0] f);
    int wait_cyc = 0;
    io.in_valid   = 1'b1;
    io.in_sign    = sign;
    io.in_exp     = e;
    io.in_mant    = m;
    io.in_sticky  = sticky;
    io.in_rm      = rm;
    io.in_nan     = nan;
    io.in_invalid = inv;
    io.in_inf     = inf;
    @(negedge clk);
    while (!io.in_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!io.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready=0 for 50 cycles, expected acceptance", name);
    end else begin
      exp_q.push_back({r, f});
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  // Wait (bounded) for all queued results to come out.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 37'(exp_q.size()), 37'd0);
  endtask

  logic [MANT_W-1:0] one_m, tie_m, ones25_m, ones26_m, m_15, m_70;

  initial begin
    one_m    = MANT_W'(1) << 81;
    tie_m    = (MANT_W'(1) << 81) | (MANT_W'(1) << 57);
    ones25_m = {MANT_W{1'b1}} << 57;
    ones26_m = {MANT_W{1'b1}} << 56;
    m_15     = (MANT_W'(1) << 81) | (MANT_W'(1) << 80);
    m_70     = MANT_W'(1) << 70;

    io.in_valid = 1'b0; io.in_sign = 1'b0; io.in_exp = '0; io.in_mant = '0;
    io.in_sticky = 1'b0; io.in_rm = 3'd0; io.in_nan = 1'b0; io.in_invalid = 1'b0;
    io.in_inf = 1'b0; io.out_ready = 1'b1;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 37'(io.out_valid), 37'd0);
    check("reset_rslt_flag", {io.rslt, io.flag}, 37'd0);
    check("reset_in_ready",  37'(io.in_ready), 37'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1.0 and its latency: presented in cycle 0, visible in cycle 2
    send("one_rne", 0, 10'sd127, one_m, 0, RNE, 0, 0, 0, 32'h3f800000, 5'h00);
    check("lat_not_early", 37'(io.out_valid), 37'd0);
    @(posedge clk); #1;
    check("lat_two_cycles", 37'(io.out_valid), 37'd1);
    drain("t1");

    // Half-ulp tie and other rounding modes
    send("tie_rne", 0, 10'sd127, tie_m, 0, RNE, 0, 0, 0, 32'h3f800000, 5'h01);
    send("tie_rup", 0, 10'sd127, tie_m, 0, RUP, 0, 0, 0, 32'h3f800001, 5'h01);
    send("tie_rmm", 0, 10'sd127, tie_m, 0, RMM, 0, 0, 0, 32'h3f800001, 5'h01);
    send("neg_rdn_st", 1, 10'sd127, one_m, 1, RDN, 0, 0, 0, 32'hbf800001, 5'h01);
    send("normalize_lz11", 0, 10'sd138, m_70, 0, RNE, 0, 0, 0, 32'h3f800000, 5'h00);

    // Overflow
    send("of_rne", 0, 10'sd255, one_m, 0, RNE, 0, 0, 0, 32'h7f800000, 5'h05);
    send("of_rtz", 0, 10'sd255, one_m, 0, RTZ, 0, 0, 0, 32'h7f7fffff, 5'h05);
    send("of_round_carry", 0, 10'sd254, ones25_m, 0, RNE, 0, 0, 0, 32'h7f800000, 5'h05);
    send("max_rtz", 0, 10'sd254, ones25_m, 0, RTZ, 0, 0, 0, 32'h7f7fffff, 5'h01);

    // Underflow / subnormal
`ifdef FMAS_NRM_FTZ_EN
    send("sub_exact", 0, 10'sd0, one_m, 0, RNE, 0, 0, 0, 32'h00000000, 5'h03);
    send("sub_sticky", 0, 10'sd0, one_m, 1, RNE, 0, 0, 0, 32'h00000000, 5'h03);
    send("sub_carry_norm", 0, 10'sd0, ones26_m, 0, RNE, 0, 0, 0, 32'h00000000, 5'h03);
    send("deep_rne", 0, -10'sd30, one_m, 0, RNE, 0, 0, 0, 32'h00000000, 5'h03);
    send("deep_rup", 0, -10'sd30, one_m, 0, RUP, 0, 0, 0, 32'h00000000, 5'h03);
`else
    send("sub_exact", 0, 10'sd0, one_m, 0, RNE, 0, 0, 0, 32'h00400000, 5'h00);
    send("sub_sticky", 0, 10'sd0, one_m, 1, RNE, 0, 0, 0, 32'h00400000, 5'h03);
    send("sub_carry_norm", 0, 10'sd0, ones26_m, 0, RNE, 0, 0, 0, 32'h00800000, 5'h03);
    send("deep_rne", 0, -10'sd30, one_m, 0, RNE, 0, 0, 0, 32'h00000000, 5'h03);
    send("deep_rup", 0, -10'sd30, one_m, 0, RUP, 0, 0, 0, 32'h00000001, 5'h03);
`endif

    // Zero and specials
    send("exact_zero_neg", 1, 10'sd50, '0, 0, RNE, 0, 0, 0, 32'h80000000, 5'h00);
    send("nan_invalid", 0, 10'sd127, tie_m, 1, RNE, 1, 1, 1, 32'h7fc00000, 5'h10);
    send("nan_quiet", 1, 10'sd3, one_m, 0, RUP, 1, 0, 0, 32'h7fc00000, 5'h00);
    send("inf_neg", 1, 10'sd127, tie_m, 1, RNE, 0, 0, 1, 32'hff800000, 5'h00);
    drain("directed");

    // Backpressure: out_ready low for 5 cycles while 4 beats stream in
    io.out_ready = 1'b0;
    fork
      begin
        send("bp_one",  0, 10'sd127, one_m, 0, RNE, 0, 0, 0, 32'h3f800000, 5'h00);
        send("bp_two",  0, 10'sd128, one_m, 0, RNE, 0, 0, 0, 32'h40000000, 5'h00);
        send("bp_neg",  1, 10'sd127, one_m, 0, RNE, 0, 0, 0, 32'hbf800000, 5'h00);
        send("bp_1p5",  0, 10'sd127, m_15,  0, RNE, 0, 0, 0, 32'h3fc00000, 5'h00);
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        check("bp_in_ready_low", 37'(io.in_ready), 37'd0);
        check("bp_held_out", {io.rslt, io.flag}, {32'h3f800000, 5'h00});
        check("bp_out_valid", 37'(io.out_valid), 37'd1);
        check("bp_two_queued", 37'(exp_q.size()), 37'd2);
        io.out_ready = 1'b1;
      end
    join
    drain("bp");

    // Reset in mid-stream drops both in-flight beats
    io.out_ready = 1'b0;
    io.in_valid = 1'b1; io.in_sign = 1'b0; io.in_exp = 10'sd127; io.in_mant = one_m;
    io.in_sticky = 1'b0; io.in_rm = 3'd0; io.in_nan = 1'b0; io.in_invalid = 1'b0; io.in_inf = 1'b0;
    @(posedge clk); #1;
    io.in_exp = 10'sd128;
    @(posedge clk); #1;
    check("rst_pre_out_valid", 37'(io.out_valid), 37'd1);
    reset = 1'b1;
    io.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", 37'(io.out_valid), 37'd0);
    check("rst_rslt_flag", {io.rslt, io.flag}, 37'd0);
    reset = 1'b0;
    io.out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("rst_no_stale_out", 37'(io.out_valid), 37'd0);

    // Recovery after reset
    send("post_reset", 0, 10'sd127, tie_m, 0, RTZ, 0, 0, 0, 32'h3f800000, 5'h01);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
